// File: rtl/load_store_unit_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // The RAM returns byte aligned+k in bits [31-8k:24-8k]; reverse it so
    // byte aligned+k sits in bits [8k+7:8k], matching the write-side order.
    function automatic logic [31:0] lane_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return (size == 2'b11)
            || (size == SZ_HALF && offset[0])
            || (size == SZ_WORD && offset != 2'b00);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response handshake plus the RAM port, bundled for the LSU.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_readEnable;
    logic              mem_writeEnable;
    logic [31:0]       mem_writeData;
    logic [31:0]       mem_readData;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_readData,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_readEnable, mem_writeEnable, mem_writeData
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_readData,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_readEnable, mem_writeEnable, mem_writeData
    );
endinterface

// File: rtl/load_store_unit_byte_lane_align.sv
// Byte-lane datapath: swaps RAM read data, merges sub-word stores, extracts loads.
module byte_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [31:0] lw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign lw       = lane_swap(rd_word_i);
    assign byte_sel = lw[{offset_i, 3'b000} +: 8];
    assign half_sel = lw[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: both outputs get a default before the case, so no path infers a latch.
        merged_o = lw;
        load_o   = lw;
        case (size_i)
            SZ_BYTE: begin
                merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
                load_o = unsigned_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
                load_o = unsigned_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: request FSM with registered RAM strobes and response outputs.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    lsu_state_e        state_q;
    logic              write_q;
    logic              unsigned_q;
    logic [1:0]        size_q;
    logic [1:0]        offset_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic [31:0]       mem_wdata_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [31:0]       resp_rdata_q;

    logic [31:0]       merged_d;
    logic [31:0]       load_d;
    logic [ADDR_W-1:0] aligned_d;

    assign aligned_d = {bus.req_addr[ADDR_W-1:2], 2'b00};

    byte_lane_align u_align (
        .rd_word_i  (bus.mem_readData),
        .offset_i   (offset_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .wdata_i    (wdata_q),
        .merged_o   (merged_d),
        .load_o     (load_d)
    );

    // Ready is gated by rst so nothing is accepted while reset is held.
    assign bus.req_ready       = ~rst & (state_q == IDLE);
    assign bus.mem_address     = mem_addr_q;
    assign bus.mem_readEnable  = mem_re_q;
    assign bus.mem_writeEnable = mem_we_q;
    assign bus.mem_writeData   = mem_wdata_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_err        = resp_err_q;
    assign bus.resp_rdata      = resp_rdata_q;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= SZ_BYTE;
            offset_q     <= 2'b00;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        write_q    <= bus.req_write;
                        unsigned_q <= bus.req_unsigned;
                        size_q     <= bus.req_size;
                        offset_q   <= bus.req_addr[1:0];
                        wdata_q    <= bus.req_wdata;
                        if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (bus.req_write && bus.req_size == SZ_WORD) begin
                            state_q     <= WRITE;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= aligned_d;
                            mem_wdata_q <= bus.req_wdata;
                        end else begin
                            state_q    <= READ;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= aligned_d;
                        end
                    end
                end
                READ: begin
                    mem_re_q <= 1'b0;
                    if (write_q) begin
                        // Sub-word store: merge the fresh read word and write it back.
                        state_q     <= WRITE;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merged_d;
                    end else begin
                        state_q      <= RESP;
                        mem_addr_q   <= '0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_d;
                    end
                end
                WRITE: begin
                    state_q      <= RESP;
                    mem_we_q     <= 1'b0;
                    mem_addr_q   <= '0;
                    mem_wdata_q  <= '0;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: byte-array memory model, response scoreboard, random and directed requests.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADDR_W = 32;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t        exp_q[$];
    logic [7:0]  ram [256];
    logic [7:0]  mm  [256];
    logic [31:0] rd_q = '0;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM: samples strobes on negedge, read data valid at the following posedge.
    assign bus.mem_readData = rd_q;
    always @(negedge clk) begin
        if (bus.mem_writeEnable)
            for (int k = 0; k < 4; k++)
                ram[8'(bus.mem_address[7:0] + 8'(k))] <= bus.mem_writeData[8*k +: 8];
        if (bus.mem_readEnable)
            rd_q <= {ram[bus.mem_address[7:0]],
                     ram[8'(bus.mem_address[7:0] + 8'd1)],
                     ram[8'(bus.mem_address[7:0] + 8'd2)],
                     ram[8'(bus.mem_address[7:0] + 8'd3)]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        logic [7:0]  i;
        logic [15:0] h;
        i = a[7:0];
        h = {mm[8'(i + 8'd1)], mm[i]};
        case (sz)
            2'b00:   return uns ? {24'd0, mm[i]} : {{24{mm[i][7]}}, mm[i]};
            2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return {mm[8'(i + 8'd3)], mm[8'(i + 8'd2)], h};
        endcase
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) mm[8'(a[7:0] + 8'(k))] = wd[8*k +: 8];
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [7:0] al;
        al = {a[7:2], 2'b00};
        return {mm[8'(al + 8'd3)], mm[8'(al + 8'd2)], mm[8'(al + 8'd1)], mm[al]};
    endfunction

    // Scoreboard monitor: every response must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_err", 32'(bus.resp_err), 32'(e.err));
                check("resp_rdata", bus.resp_rdata, e.rdata);
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] seen_wd, output int lat);
        int   guard, n_re, n_we, exp_lat;
        logic err, word_st, ready_low, addr_ok;
        exp_t e;
        seen_wd = '0; lat = 0; guard = 0; n_re = 0; n_we = 0;
        ready_low = 1'b1; addr_ok = 1'b1;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            check("ready_timeout", 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_write = w; bus.req_size = sz; bus.req_unsigned = uns;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
        err     = misaligned(sz, a);
        word_st = w && sz == 2'b10;
        e.err   = err;
        e.rdata = (err || w) ? 32'd0 : model_load(sz, uns, a);
        exp_q.push_back(e);
        if (w && !err) model_store(sz, a, wd);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.req_ready) ready_low = 1'b0;
            if ((bus.mem_readEnable || bus.mem_writeEnable) && bus.mem_address !== {a[31:2], 2'b00})
                addr_ok = 1'b0;
            if (bus.mem_readEnable) n_re++;
            if (bus.mem_writeEnable) begin
                n_we++;
                seen_wd = bus.mem_writeData;
            end
        end while (!bus.resp_valid && lat < 10);
        exp_lat = err ? 1 : word_st ? 2 : w ? 3 : 2;
        check("latency", lat, exp_lat);
        check("read_strobes", n_re, (err || word_st) ? 0 : 1);
        check("write_strobes", n_we, (!err && w) ? 1 : 0);
        check("ready_low_busy", 32'(ready_low), 32'd1);
        check("mem_address", 32'(addr_ok), 32'd1);
        if (!err && w) check("write_data", seen_wd, model_word(a));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] wd, a, seen;
        logic [1:0]  sz;
        logic        w, uns;
        logic [7:0]  v;
        int          lat, guard;
        exp_t        e;

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            ram[i] <= v;
            mm[i] = v;
        end

        // Reset state.
        #12;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_mem_re", 32'(bus.mem_readEnable), 32'd0);
        check("rst_mem_we", 32'(bus.mem_writeEnable), 32'd0);
        check("rst_mem_address", bus.mem_address, 32'd0);
        check("rst_mem_wdata", bus.mem_writeData, 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp", {bus.resp_err, bus.resp_rdata[30:0]}, 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 check("ready_after_release", 32'(bus.req_ready), 32'd1);

        // Word store, word load.
        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, seen, lat);
        check("t1_wdata", seen, 32'hDEADBEEF);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, seen, lat);
        // Byte store via read-modify-write.
        issue(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h123456A5, seen, lat);
        check("t2_wdata", seen, 32'hDEADA5EF);
        check("t2_latency", lat, 3);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, seen, lat);
        // Load extension.
        issue(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, seen, lat);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, seen, lat);
        issue(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, seen, lat);
        issue(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, seen, lat);
        // Misaligned and illegal size.
        issue(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, seen, lat);
        issue(1'b1, SZ_HALF, 1'b0, 32'h11, 32'hFFFF, seen, lat);
        issue(1'b1, 2'b11, 1'b0, 32'h14, 32'h1, seen, lat);

        // Reset during the READ of a byte store: abandoned, memory untouched.
        @(negedge clk);
        bus.req_write = 1'b1; bus.req_size = SZ_BYTE; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h5A; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check("t5_in_read", 32'(bus.mem_readEnable), 32'd1);
        #2 rst = 1'b1;
        #1 check("t5_strobes_drop", {30'd0, bus.mem_readEnable, bus.mem_writeEnable}, 32'd0);
        check("t5_ready_in_rst", 32'(bus.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("t5_no_resp", 32'(bus.resp_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1 check("t5_ready_after", 32'(bus.req_ready), 32'd1);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, seen, lat);

        // Back-to-back with req_valid held: load then byte store.
        @(negedge clk);
        bus.req_write = 1'b0; bus.req_size = SZ_WORD; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h10; bus.req_valid = 1'b1;
        e.err = 1'b0; e.rdata = model_load(SZ_WORD, 1'b0, 32'h10);
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.req_write = 1'b1; bus.req_size = SZ_BYTE; bus.req_addr = 32'h13;
        bus.req_wdata = 32'h3C;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            check("t6_ready_low", 32'(bus.req_ready), 32'd0);
        end while (!bus.resp_valid && guard < 10);
        e.err = 1'b0; e.rdata = 32'd0;
        exp_q.push_back(e);
        model_store(SZ_BYTE, 32'h13, 32'h3C);
        @(negedge clk);
        check("t6_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check("t6_accepted_once", 32'(bus.req_ready), 32'd0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid && lat < 10);
        check("t6_second_latency", lat, 3);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, seen, lat);

        // Randomized traffic over a small window with random upper address bits.
        for (int n = 0; n < 200; n++) begin
            sz  = 2'($urandom_range(0, 3));
            w   = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            a   = $urandom;
            a[7:0] = 8'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == SZ_HALF) a[0] = 1'b0;
                if (sz == SZ_WORD) a[1:0] = 2'b00;
            end
            issue(w, sz, uns, a, wd, seen, lat);
        end

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-side initiator for the byte-addressed, 32-bit word RAM port. Accepts byte/halfword/word load and store requests from the core over a valid/ready handshake and drives the RAM's `address`/`readEnable`/`writeEnable`/`writeData`/`readData` port. Sub-word stores are done as aligned read-modify-write, and loads are sign- or zero-extended. It sits between the datapath's memory stage and the RAM.

## Interface
- `ADDR_W`, 32, address width (request and memory side)
- `clk`  in  1  clock; RAM shares it
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle; request accepted on a posedge with `req_valid & req_ready`
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word; 11 is treated as misaligned
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  32  store data, low-aligned
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  load result; 0 for stores and errors
- `resp_err`  out  1  misaligned or illegal size; valid with `resp_valid`
- `mem_address`  out  ADDR_W  word-aligned address (`addr & ~3`)
- `mem_readEnable`  out  1  RAM read strobe
- `mem_writeEnable`  out  1  RAM write strobe
- `mem_writeData`  out  32  bits [8k+7:8k] are written to byte `aligned+k`
- `mem_readData`  in  32  bits [31-8k:24-8k] hold byte `aligned+k`; the RAM samples on negedge, so the data is valid at the next posedge

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- **IDLE:** `req_ready=1`. On accept, register `addr`, `size`, `write`, `unsigned`, `wdata`, then branch:
  - misaligned (half with `addr[0]`, word with `addr[1:0]≠0`, or size 11): RESP with `err=1`
  - word store: WRITE
  - otherwise: READ
- **READ:**
  - Drive `mem_readEnable=1` and `mem_address=aligned` for one cycle.
  - At the posedge, capture `lw` = byte-swapped `mem_readData`, so that byte `aligned+k` lands in `lw[8k+7:8k]`.
  - Load goes to RESP; sub-word store goes to WRITE.
- **WRITE:**
  - Drive `mem_writeEnable=1` for one cycle with `mem_address=aligned`.
  - `mem_writeData` is either the word-store data or the merge: `lw` with byte `addr[1:0]` (or half `addr[1]`) replaced by `wdata[7:0]` (or `wdata[15:0]`).
  - Then go to RESP.
- **RESP:** `resp_valid=1` for one cycle, then IDLE.
- **Load extract:**
  - byte: `lw >> 8*addr[1:0]`, bits [7:0]
  - half: `lw >> 16*addr[1]`, bits [15:0]
  - extend per `req_unsigned`; a word load returns `lw` unchanged
- **Register-only drive:** all `mem_*` outputs and `resp_*` derive from state and registered fields only. There is no combinational path from `req_*`.
- **Inactive values:** `mem_*` is 0 when not in READ/WRITE; `resp_*` is 0 outside RESP.
- **Unchecked cases:** address range is not checked. Because the address is aligned, there is no intra-word wrap.

## Timing
- Reset (async): state IDLE; `mem_readEnable=0`, `mem_writeEnable=0`, `mem_address=0`, `mem_writeData=0`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`. `req_ready` is forced 0 while `rst` is high and is 1 from the first cycle after release.
- Latency from the accept edge to the `resp_valid` cycle:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 2 cycles
  - sub-word store: 3 cycles
- Throughput is one request in flight. `req_ready=0` from the cycle after accept through RESP. The next accept can occur in the cycle after `resp_valid`.
- `req_*` is ignored when not in IDLE. A request held high across RESP is accepted exactly once, in the following IDLE cycle.
- Reset mid-operation: the operation is abandoned with no response.
  - Strobes drop asynchronously.
  - A write whose WRITE-cycle posedge has not occurred does not happen.
  - A RMW interrupted in READ leaves memory unchanged.

## Structure
- Package `lsu_pkg` holds:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`
  - state enum constants
  - `lane_swap` byte-reverse function
- Sub-module `byte_lane_align` (combinational) does the swap, merge and extract/extend. The FSM/registers stay in `load_store_unit`.

## Test plan
1. Word store 0xDEADBEEF @0x10: WRITE cycle shows `mem_writeData=0xDEADBEEF`, `resp_valid` 2 cycles after accept. Word load @0x10 then gives `resp_rdata=0xDEADBEEF`.
2. Byte store 0xA5 @0x11 after case 1: a READ cycle, then a WRITE cycle with `mem_writeData=0xDEADA5EF`, `resp_valid` 3 cycles after accept. A word load @0x10 returns 0xDEADA5EF.
3. After case 2, check load extension:
   - signed byte load @0x11 returns 0xFFFFFFA5
   - unsigned byte load @0x11 returns 0x000000A5
   - signed half load @0x12 returns 0xFFFFDEAD
   - unsigned half load @0x12 returns 0x0000DEAD
4. Word load @0x13 and half store @0x11:
   - each gives `resp_valid=1`, `resp_err=1`, `resp_rdata=0` one cycle after accept
   - no `mem_readEnable`/`mem_writeEnable` pulse
5. Assert `rst` during the READ of a byte store @0x10:
   - strobes go 0 immediately
   - no `resp_valid`
   - word @0x10 is unchanged
   - `req_ready=1` the cycle after release
6. Two back-to-back requests with `req_valid` held high:
   - `req_ready` stays low between accept and RESP
   - the second request is accepted in the cycle after the first `resp_valid`
   - both responses are correct and in order
